// File: rtl/m0_assembler.sv
// Beat-to-vector assembler feeding layer input M0: collects BEATS narrow beats
// (first beat at the LSBs) into one IN_WIDTH vector behind a one-deep output register.
module m0_assembler #(
  parameter int IN_WIDTH   = 25,
  parameter int BEAT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [BEAT_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [IN_WIDTH-1:0]   m_data,
  output logic                  err,
  output logic [7:0]            err_count
);

  localparam int BEATS = IN_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]   asm_q, asm_d;
  logic [IN_WIDTH-1:0]   out_q, out_d;
  logic                  mvalid_q, mvalid_d;
  logic                  err_q, err_d;
  logic [7:0]            errcnt_q, errcnt_d;
  logic                  is_last;

  assign is_last = (cnt_q == LAST_CNT);

  // A beat whose s_last disagrees with the counter position is a framing error;
  // a good final beat either goes straight to the output register or parks in HOLD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    out_d    = out_q;
    mvalid_d = mvalid_q;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (mvalid_q && m_ready) begin
      mvalid_d = 1'b0;
    end

    if (state_q == HOLD) begin
      if (m_ready) begin
        out_d    = asm_q;
        mvalid_d = 1'b1;
        state_d  = FILL;
      end
    end else if (s_valid) begin
      for (int k = 0; k < BEATS; k++) begin
        if (cnt_q == CNT_W'(k)) begin
          asm_d[k*BEAT_WIDTH +: BEAT_WIDTH] = s_data;
        end
      end
      if (s_last != is_last) begin
        cnt_d = '0;
        asm_d = '0;
        err_d = 1'b1;
        if (errcnt_q != 8'hFF) begin
          errcnt_d = errcnt_q + 8'd1;
        end
      end else if (is_last) begin
        cnt_d = '0;
        if (!mvalid_q || m_ready) begin
          out_d    = asm_d;
          mvalid_d = 1'b1;
        end else begin
          state_d = HOLD;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      asm_q    <= '0;
      out_q    <= '0;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      out_q    <= out_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Gated by rst_n so no beat is offered while reset is held, yet ready is
  // up immediately once it releases.
  assign s_ready   = rst_n && (state_q == FILL);
  assign m_valid   = mvalid_q;
  assign m_data    = out_q;
  assign err       = err_q;
  assign err_count = errcnt_q;

endmodule

// File: doc/m0_assembler.md
M0_ASSEMBLER -- requirements
Module: m0_assembler

Interface
REQ-001 Parameter IN_WIDTH, default 25, SHALL set the width of the assembled layer input vector.
REQ-002 Parameter BEAT_WIDTH, default 5, SHALL set the bits per input beat; IN_WIDTH SHALL be an integer multiple of BEAT_WIDTH, and BEATS = IN_WIDTH/BEAT_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 s_valid  input  1  SHALL flag a valid input beat.
REQ-006 s_ready  output  1  SHALL flag that a beat can be accepted.
REQ-007 s_data  input  BEAT_WIDTH  SHALL be the beat payload.
REQ-008 s_last  input  1  SHALL mark the final beat of a vector.
REQ-009 m_valid  output  1  SHALL flag a complete vector on m_data.
REQ-010 m_ready  input  1  SHALL flag that the downstream layer consumes m_data.
REQ-011 m_data  output  IN_WIDTH  SHALL be the assembled vector, driving layer input M0.
REQ-012 err  output  1  SHALL pulse one cycle per framing error.
REQ-013 err_count  output  8  SHALL count framing errors, saturating at 255.

Function
REQ-014 A beat SHALL be accepted on a rising edge where s_valid and s_ready are both 1.
REQ-015 Beat k (0-based) of a vector SHALL occupy bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH] of the vector (first beat at the LSBs).
REQ-016 The block SHALL hold a beat counter 0..BEATS-1, an assembly register, and an output register driving m_data.
REQ-017 States SHALL be FILL (accepting beats; s_ready=1) and HOLD (complete vector in assembly register, output register occupied; s_ready=0).
REQ-018 Final beat (counter = BEATS-1 and s_last=1) accepted with m_valid=0, or with m_valid=1 and m_ready=1 in the same cycle: the complete vector SHALL load the output register at that edge, m_valid=1 the next cycle, counter to 0, and the state SHALL remain FILL.
REQ-019 Final beat accepted with m_valid=1 and m_ready=0: the state SHALL go to HOLD.
REQ-020 In HOLD, on the first edge with m_ready=1, the held vector SHALL move to the output register, m_valid SHALL stay 1, and the state SHALL return to FILL.
REQ-021 m_valid SHALL clear on an edge with m_ready=1 when no new vector is being loaded.
REQ-022 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-023 Beat-to-output latency SHALL be one cycle when the output register is free.
REQ-024 Framing error conditions SHALL be: s_last=1 on a beat with counter < BEATS-1, or s_last=0 on a beat with counter = BEATS-1.
REQ-025 On a framing error, the beat SHALL be accepted and the partial vector discarded; the counter SHALL reset to 0, err SHALL be 1 for the next cycle, err_count SHALL increment (saturating), and m_valid/m_data SHALL be unaffected.
REQ-026 Back-to-back vectors SHALL sustain one beat per cycle when m_ready is held at 1.

Reset
REQ-027 While rst_n=0, the following SHALL hold: state=FILL, counter=0, assembly register=0, m_valid=0, m_data=0, err=0, err_count=0, s_ready=0.
REQ-028 s_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-029 Reset asserted mid-vector or in HOLD SHALL discard all partial and held data, with no m_valid pulse afterwards until a new full vector arrives.

Verification
REQ-030 Basic assembly: defaults, m_ready=1, beats 0x01,0x02,0x03,0x04,0x1F (s_last on 5th) -> m_valid=1 the cycle after the 5th beat, with m_data=0x1F20C41.
REQ-031 Backpressure: m_ready=0, two full vectors A then B -> A presented and held; s_ready=0 after B's last beat; m_ready=1 one cycle -> B presented the next cycle; s_ready=1.
REQ-032 Early s_last: s_last on 3rd beat -> err pulse 1 cycle, err_count=1, no m_valid; the following 5-beat vector assembles correctly.
REQ-033 Missing s_last: 5 beats with s_last=0 -> err pulse, err_count increments, no m_valid; 300 such errors -> err_count=255.
REQ-034 Reset mid-vector: rst_n low after beat 2 of 5, then released -> all outputs 0; next full vector output correct, with no stale bits.
REQ-035 Throughput: 4 vectors streamed continuously, m_ready=1 -> 4 m_valid pulses spaced 5 cycles apart, with no bubbles on s_ready.
